div_seq_controller: RTL

Parametrised sequencing controller for the shift/add restoring divider datapath. It replaces the fixed 8-iteration controller with a WIDTH-generic design. It adds a start/busy/valid handshake that ignores start while busy, and holds the result until the next start. It also provides optional divide-by-zero short-circuiting. It drives the same datapath control lines (load, add, shift, inbit, sel) and sits between the top-level divider wrapper and the register/ALU datapath.

---
 rtl/div_seq_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/div_seq_controller.sv
// rtl/div_seq_controller.sv - WIDTH-generic sequencing controller for a restoring shift/add divider
//
// Purpose:
//   Drives the register/ALU datapath of a restoring divider through WIDTH
//   test/decide iterations. A start/busy/valid handshake wraps the sequence.
//   start is ignored while a division is running, and the result stays valid
//   until the next start is accepted.
//
// Configuration macro:
//   DIVZERO_DETECT_EN - when defined, a start that sees div_zero=1 goes
//                       straight to DONE with err=1 and never touches the
//                       datapath. When undefined, div_zero is ignored and err
//                       is constant 0.
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous, active-low reset
//   start     in   1  request a new division (sampled on clk rise)
//   sign      in   1  sign of the trial remainder (1 = negative), used in TEST
//   div_zero  in   1  divisor-is-zero flag from the datapath
//   load      out  1  load operands into datapath registers
//   add       out  1  restore enable (add divisor back)
//   shift     out  1  shift the remainder/quotient pair left
//   inbit     out  1  quotient bit shifted in
//   sel       out  2  datapath mux: 0 hold, 1 ALU, 2 operand load, 3 shift path
//   busy      out  1  division in progress
//   valid     out  1  quotient/remainder valid
//   err       out  1  divide-by-zero flag, qualified by valid

module div_seq_controller #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sign,
  input  logic       div_zero,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel,
  output logic       busy,
  output logic       valid,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_TEST    = 3'd2,
    S_RESTORE = 3'd3,
    S_ACCEPT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_iter;
  logic             start_zero;
  logic             err_q;

  // Saturating increment: the counter stops at WIDTH and never wraps.
  assign cnt_inc   = (cnt == CNT_LAST) ? cnt : (cnt + CNT_ONE);
  assign last_iter = (cnt_inc == CNT_LAST);

`ifdef DIVZERO_DETECT_EN
  assign start_zero = div_zero;

  // err is captured when a start is accepted, so it reflects the division
  // whose result is currently held, and is cleared by the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (start && (state == S_IDLE || state == S_DONE)) begin
      err_q <= div_zero;
    end
  end
`else
  logic unused_div_zero;

  assign unused_div_zero = div_zero;
  assign start_zero      = 1'b0;
  assign err_q           = 1'b0;
`endif

  // State register and iteration counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_LOAD:              cnt <= '0;
        S_RESTORE, S_ACCEPT: cnt <= cnt_inc;
        default:             cnt <= cnt;
      endcase
    end
  end

  // Next-state logic. Only IDLE and DONE look at start, so a running
  // division cannot be restarted.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = start_zero ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:    state_next = S_TEST;
      S_TEST:    state_next = sign ? S_RESTORE : S_ACCEPT;
      S_RESTORE: state_next = last_iter ? S_DONE : S_TEST;
      S_ACCEPT:  state_next = last_iter ? S_DONE : S_TEST;
      default:   state_next = S_IDLE;
    endcase
  end

  // Moore output decode; every output has a defined value in every state.
  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    inbit = 1'b0;
    sel   = 2'd0;
    busy  = 1'b0;
    valid = 1'b0;
    case (state)
      S_LOAD: begin
        load  = 1'b1;
        shift = 1'b1;
        sel   = 2'd2;
        busy  = 1'b1;
      end
      S_TEST: begin
        sel  = 2'd1;
        busy = 1'b1;
      end
      S_RESTORE: begin
        add   = 1'b1;
        shift = 1'b1;
        sel   = 2'd1;
        busy  = 1'b1;
      end
      S_ACCEPT: begin
        shift = 1'b1;
        inbit = 1'b1;
        sel   = 2'd3;
        busy  = 1'b1;
      end
      S_DONE: begin
        valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign err = err_q & valid;

endmodule
